clint_timer: RTL and testbench

Machine-level timer and software-interrupt unit. It holds the 64-bit `mtime` and `mtimecmp` registers and the `msip` bit, and exposes them through a single-beat memory-mapped port driven by the load/store unit. It produces registered `timer_irq` and `soft_irq` levels, which feed the MTIP (bit 7) and MSIP (bit 3) pending inputs of the machine CSR file. The external interrupt (bit 11) does not pass through this block.

---
 rtl/clint_pkg.sv | 42 ++++
 rtl/clint_timer_if.sv | 38 +++
 rtl/clint_prescaler.sv | 28 ++
 rtl/clint_timer.sv | 141 ++++++++++++++
 tb/tb_clint_timer.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/clint_pkg.sv
// clint_timer shared definitions: register offsets,
// reset constants and the register-select encoding.
package clint_pkg;

   localparam logic [7:0] MTIME_LO    = 8'h00;
   localparam logic [7:0] MTIME_HI    = 8'h04;
   localparam logic [7:0] MTIMECMP_LO = 8'h08;
   localparam logic [7:0] MTIMECMP_HI = 8'h0C;
   localparam logic [7:0] MSIP        = 8'h10;

   localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;
   localparam logic [63:0] MTIME_RST    = 64'h0;

   typedef enum logic [2:0] {
      SEL_MTIME_LO,
      SEL_MTIME_HI,
      SEL_CMP_LO,
      SEL_CMP_HI,
      SEL_MSIP,
      SEL_NONE
   } reg_sel_e;

   typedef struct packed {
      logic        valid;
      logic        err;
      logic [31:0] rdata;
   } rsp_t;

   // Replace one 32-bit half of a 64-bit register.
   function automatic logic [63:0] put_half(
      input logic [63:0] cur,
      input logic        hi,
      input logic [31:0] val
   );
      logic [63:0] r;
      r = cur;
      if (hi) r[63:32] = val;
      else    r[31:0]  = val;
      return r;
   endfunction

endpackage

// File: rtl/clint_timer_if.sv
// Single-beat request/response port between the
// load/store unit (master) and the timer block (slave).
interface clint_timer_if #(
   parameter int unsigned ADDR_W = 5
);

   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_wdata;
   logic              rsp_valid;
   logic [31:0]       rsp_rdata;
   logic              rsp_err;

   modport master (
      output req_valid,
      output req_we,
      output req_addr,
      output req_wdata,
      input  req_ready,
      input  rsp_valid,
      input  rsp_rdata,
      input  rsp_err
   );

   modport slave (
      input  req_valid,
      input  req_we,
      input  req_addr,
      input  req_wdata,
      output req_ready,
      output rsp_valid,
      output rsp_rdata,
      output rsp_err
   );

endinterface

// File: rtl/clint_prescaler.sv
// mtime prescaler: counts 0..DIV-1 and flags the
// wrap cycle so mtime advances once per DIV clocks.
module clint_prescaler #(
   parameter int unsigned DIV = 1
) (
   input  logic clk,
   input  logic reset_n,
   output logic tick
);

   localparam logic [15:0] LAST = 16'(DIV - 1);

   logic [15:0] cnt_q;

   assign tick = (cnt_q == LAST);

   // Free-running divider counter, restarts on wrap.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= 16'h0;
      end else if (tick) begin
         cnt_q <= 16'h0;
      end else begin
         cnt_q <= cnt_q + 16'd1;
      end
   end

endmodule

// File: rtl/clint_timer.sv
// Machine timer / software interrupt unit: mtime,
// mtimecmp and msip behind a single-beat port.
module clint_timer
   import clint_pkg::*;
#(
   parameter int unsigned TICK_DIV = 1,
   parameter int unsigned ADDR_W   = 5
) (
   input  logic          clk,
   input  logic          reset_n,
   clint_timer_if.slave  bus,
   output logic          timer_irq,
   output logic          soft_irq
);

   localparam logic [ADDR_W-1:0] A_MTIME_LO = ADDR_W'(MTIME_LO);
   localparam logic [ADDR_W-1:0] A_MTIME_HI = ADDR_W'(MTIME_HI);
   localparam logic [ADDR_W-1:0] A_CMP_LO   = ADDR_W'(MTIMECMP_LO);
   localparam logic [ADDR_W-1:0] A_CMP_HI   = ADDR_W'(MTIMECMP_HI);
   localparam logic [ADDR_W-1:0] A_MSIP     = ADDR_W'(MSIP);

   logic        tick;
   logic        accept;
   logic        misal;
   logic        wr;
   reg_sel_e    sel;
   logic [31:0] rd_data;
   logic [63:0] mtime_q;
   logic [63:0] mtime_d;
   logic [63:0] cmp_q;
   logic [63:0] cmp_d;
   logic        msip_q;
   logic        msip_d;
   rsp_t        rsp_q;
   rsp_t        rsp_d;

   clint_prescaler #(
      .DIV (TICK_DIV)
   ) u_presc (
      .clk     (clk),
      .reset_n (reset_n),
      .tick    (tick)
   );

   // No response backpressure exists, so a new request
   // is always welcome, even alongside a response beat.
   assign bus.req_ready = 1'b1;
   assign accept        = bus.req_valid & bus.req_ready;
   assign misal         = |bus.req_addr[1:0];
   assign wr            = accept & bus.req_we & (sel != SEL_NONE);

   // Offset decode; misaligned or unmapped offsets select nothing.
   always_comb begin
      sel = SEL_NONE;
      if (!misal) begin
         unique case (1'b1)
            (bus.req_addr == A_MTIME_LO): sel = SEL_MTIME_LO;
            (bus.req_addr == A_MTIME_HI): sel = SEL_MTIME_HI;
            (bus.req_addr == A_CMP_LO):   sel = SEL_CMP_LO;
            (bus.req_addr == A_CMP_HI):   sel = SEL_CMP_HI;
            (bus.req_addr == A_MSIP):     sel = SEL_MSIP;
            default:                      sel = SEL_NONE;
         endcase
      end
   end

   // Read mux over the pre-update register values.
   always_comb begin
      rd_data = 32'h0;
      unique case (sel)
         SEL_MTIME_LO: rd_data = mtime_q[31:0];
         SEL_MTIME_HI: rd_data = mtime_q[63:32];
         SEL_CMP_LO:   rd_data = cmp_q[31:0];
         SEL_CMP_HI:   rd_data = cmp_q[63:32];
         SEL_MSIP:     rd_data = {31'h0, msip_q};
         default:      rd_data = 32'h0;
      endcase
   end

   // Next-state for the register file. An mtime write
   // suppresses the same-cycle increment entirely.
   always_comb begin
      mtime_d = tick ? mtime_q + 64'd1 : mtime_q;
      cmp_d   = cmp_q;
      msip_d  = msip_q;
      if (wr) begin
         unique case (sel)
            SEL_MTIME_LO: mtime_d = put_half(mtime_q, 1'b0, bus.req_wdata);
            SEL_MTIME_HI: mtime_d = put_half(mtime_q, 1'b1, bus.req_wdata);
            SEL_CMP_LO:   cmp_d   = put_half(cmp_q, 1'b0, bus.req_wdata);
            SEL_CMP_HI:   cmp_d   = put_half(cmp_q, 1'b1, bus.req_wdata);
            SEL_MSIP:     msip_d  = bus.req_wdata[0];
            default:      ;
         endcase
      end
   end

   // Response beat: one cycle after acceptance, data only on good reads.
   always_comb begin
      rsp_d.valid = accept;
      rsp_d.err   = accept & (sel == SEL_NONE);
      rsp_d.rdata = (accept & ~bus.req_we) ? rd_data : 32'h0;
   end

   // Timer and software-interrupt registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mtime_q <= MTIME_RST;
         cmp_q   <= MTIMECMP_RST;
         msip_q  <= 1'b0;
      end else begin
         mtime_q <= mtime_d;
         cmp_q   <= cmp_d;
         msip_q  <= msip_d;
      end
   end

   // Response pipeline register; reset drops any beat in flight.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rsp_q <= '0;
      end else begin
         rsp_q <= rsp_d;
      end
   end

   // Registered level compare, one edge behind the registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         timer_irq <= 1'b0;
      end else begin
         timer_irq <= (mtime_q >= cmp_q);
      end
   end

   assign soft_irq      = msip_q;
   assign bus.rsp_valid = rsp_q.valid;
   assign bus.rsp_err   = rsp_q.err;
   assign bus.rsp_rdata = rsp_q.rdata;

endmodule

// File: tb/tb_clint_timer.sv
// Bench for clint_timer: vector table, hand sequences and
// random traffic against an arithmetic register model.
module tb_clint_timer;

   logic clk;
   logic reset_n;
   logic t1_irq;
   logic s1_irq;
   logic t4_irq;
   logic s4_irq;

   int n_pass;
   int n_tot;
   bit done4;

   clint_timer_if #(.ADDR_W(5)) b1 ();
   clint_timer_if #(.ADDR_W(5)) b4 ();

   clint_timer #(.TICK_DIV(1), .ADDR_W(5)) u1 (
      .clk       (clk),
      .reset_n   (reset_n),
      .bus       (b1),
      .timer_irq (t1_irq),
      .soft_irq  (s1_irq)
   );

   clint_timer #(.TICK_DIV(4), .ADDR_W(5)) u4 (
      .clk       (clk),
      .reset_n   (reset_n),
      .bus       (b4),
      .timer_irq (t4_irq),
      .soft_irq  (s4_irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model of the TICK_DIV=1 instance: mtime simply counts clock edges.
   logic [63:0] m_time;
   logic [63:0] m_cmp;
   logic        m_msip;

   typedef struct {
      bit          we;
      logic [4:0]  addr;
      logic [31:0] wdata;
      bit          exp_err;
      bit          chk_rd;
      logic [31:0] exp_rd;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h want %h", nm, act, exp);
   endtask

   task automatic m_reset();
      m_time = 64'h0;
      m_cmp  = 64'hFFFF_FFFF_FFFF_FFFF;
      m_msip = 1'b0;
   endtask

   function automatic bit m_bad(input logic [4:0] a);
      return (a[1:0] != 2'b00) || (a > 5'h10);
   endfunction

   function automatic logic [31:0] m_read(input logic [4:0] a);
      case (a)
         5'h00:   return m_time[31:0];
         5'h04:   return m_time[63:32];
         5'h08:   return m_cmp[31:0];
         5'h0C:   return m_cmp[63:32];
         5'h10:   return {31'h0, m_msip};
         default: return 32'h0;
      endcase
   endfunction

   // One clock on u1 with an optional access; checks against the model.
   task automatic cyc(input bit v, input bit we, input logic [4:0] a,
                      input logic [31:0] d,
                      output logic o_err, output logic [31:0] o_rd);
      bit          bad;
      bit          mt_wr;
      logic [31:0] e_rd;
      logic        e_t;
      b1.req_valid = v;
      b1.req_we    = we;
      b1.req_addr  = a;
      b1.req_wdata = d;
      bad   = m_bad(a);
      e_rd  = (!we && !bad) ? m_read(a) : 32'h0;
      e_t   = (m_time >= m_cmp);
      mt_wr = 1'b0;
      if (v && we && !bad) begin
         case (a)
            5'h00: begin m_time[31:0]  = d; mt_wr = 1'b1; end
            5'h04: begin m_time[63:32] = d; mt_wr = 1'b1; end
            5'h08: m_cmp[31:0]  = d;
            5'h0C: m_cmp[63:32] = d;
            5'h10: m_msip = d[0];
            default: ;
         endcase
      end
      if (!mt_wr) m_time = m_time + 64'd1;
      @(posedge clk);
      #1;
      chk("rsp_valid", 64'(b1.rsp_valid), 64'(v));
      if (v) begin
         chk("rsp_err", 64'(b1.rsp_err), 64'(bad));
         if (!we || bad) chk("rsp_rdata", 64'(b1.rsp_rdata), 64'(e_rd));
      end
      chk("timer_irq", 64'(t1_irq), 64'(e_t));
      chk("soft_irq", 64'(s1_irq), 64'(m_msip));
      o_err = b1.rsp_err;
      o_rd  = b1.rsp_rdata;
      b1.req_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      logic        e;
      logic [31:0] r;
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 5'h0, 32'h0, e, r);
   endtask

   task automatic acc(input bit we, input logic [4:0] a,
                      input logic [31:0] d);
      logic        e;
      logic [31:0] r;
      cyc(1'b1, we, a, d, e, r);
   endtask

   // TICK_DIV=4 instance: free-running mtime and response latency.
   initial begin
      b4.req_valid = 1'b0;
      b4.req_we    = 1'b0;
      b4.req_addr  = 5'h0;
      b4.req_wdata = 32'h0;
      wait (reset_n === 1'b1);
      repeat (40) @(posedge clk);
      #1;
      chk("div4_rsp_idle", 64'(b4.rsp_valid), 64'd0);
      b4.req_valid = 1'b1;
      b4.req_addr  = 5'h00;
      @(posedge clk);
      #1;
      b4.req_valid = 1'b0;
      chk("div4_rsp_valid", 64'(b4.rsp_valid), 64'd1);
      n_tot++;
      if (b4.rsp_rdata >= 32'd9 && b4.rsp_rdata <= 32'd11) n_pass++;
      else $display("FAIL div4_mtime: got %0d want 10+-1", b4.rsp_rdata);
      @(posedge clk);
      #1;
      chk("div4_rsp_single", 64'(b4.rsp_valid), 64'd0);
      done4 = 1'b1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic        e;
      logic [31:0] r;
      logic [4:0]  a;
      logic [31:0] d;
      int          pick;
      n_pass = 0;
      n_tot  = 0;
      done4  = 1'b0;
      b1.req_valid = 1'b0;
      b1.req_we    = 1'b0;
      b1.req_addr  = 5'h0;
      b1.req_wdata = 32'h0;
      reset_n = 1'b0;

      tbl.push_back('{1'b0, 5'h08, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFF});
      tbl.push_back('{1'b0, 5'h0C, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFF});
      tbl.push_back('{1'b0, 5'h10, 32'h0, 1'b0, 1'b1, 32'h0});
      tbl.push_back('{1'b0, 5'h14, 32'h0, 1'b1, 1'b1, 32'h0});
      tbl.push_back('{1'b1, 5'h02, 32'h1234, 1'b1, 1'b1, 32'h0});
      tbl.push_back('{1'b1, 5'h12, 32'h1, 1'b1, 1'b1, 32'h0});
      tbl.push_back('{1'b0, 5'h10, 32'h0, 1'b0, 1'b1, 32'h0});
      tbl.push_back('{1'b0, 5'h0A, 32'h0, 1'b1, 1'b1, 32'h0});
      tbl.push_back('{1'b1, 5'h10, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0});
      tbl.push_back('{1'b0, 5'h10, 32'h0, 1'b0, 1'b1, 32'h1});
      tbl.push_back('{1'b1, 5'h10, 32'h0, 1'b0, 1'b0, 32'h0});
      tbl.push_back('{1'b0, 5'h10, 32'h0, 1'b0, 1'b1, 32'h0});
      tbl.push_back('{1'b1, 5'h08, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0});
      tbl.push_back('{1'b0, 5'h08, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF});
      tbl.push_back('{1'b1, 5'h0C, 32'h1, 1'b0, 1'b0, 32'h0});
      tbl.push_back('{1'b0, 5'h0C, 32'h0, 1'b0, 1'b1, 32'h1});
      tbl.push_back('{1'b0, 5'h08, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF});
      tbl.push_back('{1'b1, 5'h00, 32'h55, 1'b0, 1'b0, 32'h0});
      tbl.push_back('{1'b0, 5'h00, 32'h0, 1'b0, 1'b1, 32'h55});
      tbl.push_back('{1'b1, 5'h04, 32'hA, 1'b0, 1'b0, 32'h0});
      tbl.push_back('{1'b0, 5'h04, 32'h0, 1'b0, 1'b1, 32'hA});
      tbl.push_back('{1'b1, 5'h00, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0});
      tbl.push_back('{1'b1, 5'h04, 32'h0, 1'b0, 1'b0, 32'h0});
      tbl.push_back('{1'b0, 5'h00, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFF});
      tbl.push_back('{1'b0, 5'h04, 32'h0, 1'b0, 1'b1, 32'h1});
      tbl.push_back('{1'b1, 5'h00, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0});
      tbl.push_back('{1'b1, 5'h04, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0});
      tbl.push_back('{1'b0, 5'h00, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFF});
      tbl.push_back('{1'b0, 5'h04, 32'h0, 1'b0, 1'b1, 32'h0});
      tbl.push_back('{1'b0, 5'h1C, 32'h0, 1'b1, 1'b1, 32'h0});

      repeat (3) @(posedge clk);
      #1;
      reset_n = 1'b1;
      m_reset();
      chk("rst_timer_irq", 64'(t1_irq), 64'd0);
      chk("rst_soft_irq", 64'(s1_irq), 64'd0);
      chk("rst_rsp_valid", 64'(b1.rsp_valid), 64'd0);
      chk("rst_rsp_rdata", 64'(b1.rsp_rdata), 64'd0);
      chk("rst_rsp_err", 64'(b1.rsp_err), 64'd0);

      foreach (tbl[i]) begin
         cyc(1'b1, tbl[i].we, tbl[i].addr, tbl[i].wdata, e, r);
         chk($sformatf("vec%0d_err", i), 64'(e), 64'(tbl[i].exp_err));
         if (tbl[i].chk_rd)
            chk($sformatf("vec%0d_rdata", i), 64'(r), 64'(tbl[i].exp_rd));
      end

      // Compare threshold at 0x20 with mtime restarted from zero.
      acc(1'b1, 5'h04, 32'h0);
      acc(1'b1, 5'h00, 32'h0);
      acc(1'b1, 5'h0C, 32'h0);
      acc(1'b1, 5'h08, 32'h20);
      idle(40);
      chk("cmp_irq_high", 64'(t1_irq), 64'd1);
      acc(1'b1, 5'h0C, 32'h1);
      chk("cmp_irq_hold", 64'(t1_irq), 64'd1);
      idle(1);
      chk("cmp_irq_fall", 64'(t1_irq), 64'd0);

      for (int i = 0; i < 300; i++) begin
         pick = $urandom_range(0, 7);
         if (pick < 5) a = 5'(pick * 4);
         else if (pick == 5) a = 5'h14;
         else a = 5'($urandom_range(0, 31));
         d = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 64))
                                         : 32'($urandom);
         cyc(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
             a, d, e, r);
      end

      // Reset while a response beat is on the port.
      acc(1'b1, 5'h0C, 32'h0);
      acc(1'b1, 5'h08, 32'h0);
      acc(1'b1, 5'h10, 32'h1);
      idle(1);
      acc(1'b0, 5'h10, 32'h0);
      chk("pre_rst_valid", 64'(b1.rsp_valid), 64'd1);
      reset_n = 1'b0;
      #1;
      chk("mid_rst_valid", 64'(b1.rsp_valid), 64'd0);
      chk("mid_rst_rdata", 64'(b1.rsp_rdata), 64'd0);
      chk("mid_rst_tirq", 64'(t1_irq), 64'd0);
      chk("mid_rst_sirq", 64'(s1_irq), 64'd0);
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      m_reset();
      acc(1'b0, 5'h08, 32'h0);
      acc(1'b0, 5'h00, 32'h0);
      acc(1'b0, 5'h10, 32'h0);
      idle(2);

      n_tot++;
      if (done4) n_pass++;
      else $display("FAIL div4_done: got 0 want 1");
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
